alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//  Registered ALU answering the stimulus side of the ALU bus: accepts operands/command qualified by INP_VALID/CE,
//  produces RES and flags (COUT, OFLOW, E, G, L, ERR). Tolerates split operand arrival with a bounded wait;
//  multiply takes one extra cycle. Sits under the UVM env as the DUT, driven/monitored on CLK.
// PARAMETERS
//  WIDTH    8   operand width; RES is WIDTH+2 bits
//  CWIDTH   4   CMD width
//  TIMEOUT  16  cycles after a partial operand at which ERR fires
// PORTS
//  CLK        in   1          clock, all state on posedge
//  RST        in   1          reset: synchronous, active-high
//  CE         in   1          clock enable; 0 = abort + clear outputs
//  INP_VALID  in   2          [0]=OPA valid, [1]=OPB valid
//  MODE       in   1          1=arithmetic, 0=logical
//  CMD        in   CWIDTH     operation select
//  CIN        in   1          carry in (arith CMD 2/3)
//  OPA, OPB   in   WIDTH      operands
//  RES        out  WIDTH+2    result
//  COUT       out  1          carry/borrow out;  OFLOW out 1 signed ovf / mult truncation
//  E, G, L    out  1 each     unsigned compare flags (CMP only)
//  ERR        out  1          illegal cmd, missing operand, timeout, bad rotate
// BEHAVIOUR
//  Reset (RST=1 at posedge): all outputs 0, FSM=IDLE, wait counter 0; RST overrides CE and any op in flight.
//  CE=0 at posedge: all outputs 0, FSM->IDLE (pending wait/multiply discarded). Outputs hold last value when CE=1, no op.
//  Latency: ops sampled at posedge k drive outputs from posedge k (visible to next-edge sampling); mult at k+1.
//  Every new result rewrites all outputs; flags not relevant to the op are 0.
//  Arith (MODE=1): 0 ADD, 1 SUB, 2 ADD+CIN, 3 SUB-CIN, 4 INC A, 5 DEC A, 6 INC B, 7 DEC B, 8 CMP,
//   9 (A+1)*(B+1), 10 (A<<1)*B. Two-operand: 0-3,8,9,10. CMD 11-15 -> ERR=1, RES=0.
//  Logic (MODE=0): 0 AND,1 NAND,2 OR,3 NOR,4 XOR,5 XNOR,6 NOT A,7 NOT B,8 A>>1,9 A<<1,10 B>>1,11 B<<1,
//   12 ROL A by B,13 ROR A by B. Two-operand: 0-5,12,13. CMD 14-15 -> ERR=1. Logic RES zero-extended.
//  ADD/SUB: RES[WIDTH:0]=full sum/diff; COUT=carry (ADD) or borrow (SUB); OFLOW=signed ovf of WIDTH-bit result.
//  INC/DEC: COUT=carry/borrow out of WIDTH bits. CMP: RES=0, exactly one of E/G/L=1.
//  Multiply: RES=product[WIDTH+1:0]; OFLOW=1 if any truncated product bit nonzero.
//  Rotate: amount=OPB[log2(WIDTH)-1:0]; any higher OPB bit set -> ERR=1, RES=0.
//  Single-operand op lacking its operand (e.g. INC A with INP_VALID=10) -> ERR=1 immediately, no wait.
//  INP_VALID=00 -> no operation.
//  FSM IDLE/WAIT/MUL:
//   IDLE: IV=11 or single-op with operand -> compute (mult -> MUL). Two-op with IV=01/10 -> latch CMD/MODE/CIN,
//    cnt=1, -> WAIT; outputs hold.
//   WAIT: IV=11 at cnt 1..TIMEOUT-1 -> compute with latched CMD/MODE/CIN, current OPA/OPB, ->IDLE (or MUL).
//    Other IV: cnt++; at cnt==TIMEOUT -> ERR=1, RES/other flags 0, ->IDLE. New CMD/MODE inputs ignored in WAIT.
//   MUL: posedge writes product, ->IDLE; inputs presented in this cycle are dropped (driver must idle).
//  Width rule: internal sums WIDTH+1 bits, product 2*WIDTH bits, all unsigned except OFLOW.
// TESTING
//  1) MODE=1 CMD=0 OPA=8'hFF OPB=8'h01 IV=11 -> next edge RES=10'h100, COUT=1, OFLOW=0, ERR=0.
//  2) MODE=1 CMD=8 OPA=5 OPB=9 -> L=1 E=0 G=0 RES=0; OPA=OPB=7 -> E=1 only.
//  3) MODE=1 CMD=0 IV=01 OPA=3, then IV=00 x15 -> ERR=1 at 16th edge after; rerun with IV=11 OPB=4 at 15th -> RES=7, ERR=0.
//  4) MODE=1 CMD=9 OPA=3 OPB=4 -> RES=20 one edge later than ADD; ADD presented next cycle dropped (RES stays 20).
//  5) CE=0 during WAIT -> all outputs 0, later IV=11 ADD 1+1 -> RES=2; RST mid-MUL -> outputs 0, no product.
//  6) MODE=0 CMD=12 OPA=8'h81 OPB=1 -> RES=10'h003; OPB=8'h10 -> ERR=1 RES=0; MODE=1 CMD=12 -> ERR=1.

Source files
------------

// File: rtl/alu_core.sv
// Registered ALU: single-cycle arithmetic/logic results, two-cycle multiply,
// and a bounded wait for operands that arrive on different cycles.
module alu_core #(
    parameter int WIDTH   = 8,
    parameter int CWIDTH  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic [1:0]        INP_VALID,
    input  logic              MODE,
    input  logic [CWIDTH-1:0] CMD,
    input  logic              CIN,
    input  logic [WIDTH-1:0]  OPA,
    input  logic [WIDTH-1:0]  OPB,
    output logic [WIDTH+1:0]  RES,
    output logic              COUT,
    output logic              OFLOW,
    output logic              E,
    output logic              G,
    output logic              L,
    output logic              ERR
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [WIDTH+1:0] res;
        logic             cout;
        logic             oflow;
        logic             e;
        logic             g;
        logic             l;
        logic             err;
    } out_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL} state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [CWIDTH-1:0] r_cmd;
    logic              r_mode;
    logic              r_cin;
    out_t              r_out;
    out_t              r_pend;

    logic [CWIDTH-1:0]     w_cmd;
    logic                  w_mode;
    logic                  w_cin;
    int                    w_op;
    logic                  w_legal;
    logic                  w_two_op;
    logic                  w_need_a;
    logic                  w_need_b;
    logic                  w_is_mul;
    logic [WIDTH:0]        w_a1;
    logic [WIDTH:0]        w_b1;
    logic [WIDTH:0]        w_ci;
    logic [WIDTH:0]        w_sum;
    logic [WIDTH:0]        w_diff;
    logic [WIDTH:0]        w_u;
    logic [WIDTH:0]        w_step;
    logic [WIDTH:0]        w_ma;
    logic [WIDTH:0]        w_mb;
    logic [2*WIDTH+1:0]    w_prod;
    logic [SHW-1:0]        w_amt;
    logic                  w_rot_bad;
    logic [WIDTH-1:0]      w_lres;
    out_t                  w_out;

    function automatic logic f_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb, input logic sub);
        if (sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic out_t f_err();
        out_t o;
        o     = '0;
        o.err = 1'b1;
        return o;
    endfunction

    // While waiting for the second operand the command captured at entry is used.
    always_comb begin
        w_cmd     = (r_state == S_WAIT) ? r_cmd  : CMD;
        w_mode    = (r_state == S_WAIT) ? r_mode : MODE;
        w_cin     = (r_state == S_WAIT) ? r_cin  : CIN;
        w_op      = int'(w_cmd);
        w_a1      = {1'b0, OPA};
        w_b1      = {1'b0, OPB};
        w_ci      = (WIDTH+1)'(w_cin && (w_op == 2 || w_op == 3));
        w_sum     = w_a1 + w_b1 + w_ci;
        w_diff    = w_a1 - w_b1 - w_ci;
        w_u       = (w_op == 4 || w_op == 5) ? w_a1 : w_b1;
        w_step    = (w_op == 4 || w_op == 6) ? w_u + (WIDTH+1)'(1) : w_u - (WIDTH+1)'(1);
        w_ma      = (w_op == 9) ? w_a1 + (WIDTH+1)'(1) : {OPA, 1'b0};
        w_mb      = (w_op == 9) ? w_b1 + (WIDTH+1)'(1) : w_b1;
        w_prod    = (2*WIDTH+2)'(w_ma) * (2*WIDTH+2)'(w_mb);
        w_amt     = OPB[SHW-1:0];
        w_rot_bad = |OPB[WIDTH-1:SHW];
        w_legal   = 1'b1;
        w_two_op  = 1'b0;
        w_need_a  = 1'b0;
        w_need_b  = 1'b0;
        w_is_mul  = 1'b0;
        w_lres    = '0;
        w_out     = '0;
        if (w_mode) begin
            case (w_op)
                0, 2: begin
                    w_two_op    = 1'b1;
                    w_out.res   = {1'b0, w_sum};
                    w_out.cout  = w_sum[WIDTH];
                    w_out.oflow = f_ovf(OPA[WIDTH-1], OPB[WIDTH-1], w_sum[WIDTH-1], 1'b0);
                end
                1, 3: begin
                    w_two_op    = 1'b1;
                    w_out.res   = {1'b0, w_diff};
                    w_out.cout  = w_diff[WIDTH];
                    w_out.oflow = f_ovf(OPA[WIDTH-1], OPB[WIDTH-1], w_diff[WIDTH-1], 1'b1);
                end
                4, 5, 6, 7: begin
                    w_need_a   = (w_op == 4 || w_op == 5);
                    w_need_b   = (w_op == 6 || w_op == 7);
                    w_out.res  = {1'b0, w_step};
                    w_out.cout = w_step[WIDTH];
                end
                8: begin
                    w_two_op = 1'b1;
                    w_out.e  = (OPA == OPB);
                    w_out.g  = (OPA > OPB);
                    w_out.l  = (OPA < OPB);
                end
                9, 10: begin
                    w_two_op    = 1'b1;
                    w_is_mul    = 1'b1;
                    w_out.res   = w_prod[WIDTH+1:0];
                    w_out.oflow = |w_prod[2*WIDTH+1:WIDTH+2];
                end
                default: begin
                    w_legal = 1'b0;
                    w_out   = f_err();
                end
            endcase
        end else begin
            case (w_op)
                0:  w_lres = OPA & OPB;
                1:  w_lres = ~(OPA & OPB);
                2:  w_lres = OPA | OPB;
                3:  w_lres = ~(OPA | OPB);
                4:  w_lres = OPA ^ OPB;
                5:  w_lres = ~(OPA ^ OPB);
                6:  w_lres = ~OPA;
                7:  w_lres = ~OPB;
                8:  w_lres = OPA >> 1;
                9:  w_lres = OPA << 1;
                10: w_lres = OPB >> 1;
                11: w_lres = OPB << 1;
                12: w_lres = (OPA << w_amt) | (OPA >> (WIDTH - int'(w_amt)));
                13: w_lres = (OPA >> w_amt) | (OPA << (WIDTH - int'(w_amt)));
                default: w_legal = 1'b0;
            endcase
            w_two_op = (w_op <= 5) || (w_op == 12) || (w_op == 13);
            w_need_a = (w_op == 6) || (w_op == 8) || (w_op == 9);
            w_need_b = (w_op == 7) || (w_op == 10) || (w_op == 11);
            if (!w_legal || ((w_op == 12 || w_op == 13) && w_rot_bad))
                w_out = f_err();
            else
                w_out.res = {2'b00, w_lres};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || !CE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (INP_VALID != 2'b00) begin
                        if (w_legal && w_two_op && INP_VALID != 2'b11) begin
                            r_cmd   <= CMD;
                            r_mode  <= MODE;
                            r_cin   <= CIN;
                            r_cnt   <= CNTW'(1);
                            r_state <= S_WAIT;
                        end else if (w_legal && !w_two_op &&
                                     ((w_need_a && !INP_VALID[0]) || (w_need_b && !INP_VALID[1]))) begin
                            r_out <= f_err();
                        end else if (w_legal && w_is_mul) begin
                            r_pend  <= w_out;
                            r_state <= S_MUL;
                        end else begin
                            r_out <= w_out;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNTW'(TIMEOUT)) begin
                        r_out   <= f_err();
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (INP_VALID == 2'b11) begin
                        r_cnt <= '0;
                        if (w_is_mul) begin
                            r_pend  <= w_out;
                            r_state <= S_MUL;
                        end else begin
                            r_out   <= w_out;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                default: begin
                    r_out   <= r_pend;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RES   = r_out.res;
    assign COUT  = r_out.cout;
    assign OFLOW = r_out.oflow;
    assign E     = r_out.e;
    assign G     = r_out.g;
    assign L     = r_out.l;
    assign ERR   = r_out.err;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: integer-level reference model compared every cycle,
// plus literal expectations for the key scenarios.
module tb_alu_core;
    localparam int TIMEOUT = 16;

    logic       CLK = 1'b0;
    logic       RST, CE, MODE, CIN;
    logic [1:0] INP_VALID;
    logic [3:0] CMD;
    logic [7:0] OPA, OPB;
    logic [9:0] RES;
    logic       COUT, OFLOW, E, G, L, ERR;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [9:0] res;
        logic cout, oflow, e, g, l, err;
    } exp_t;

    exp_t exp_o = '0;
    exp_t mul_val;
    bit   model_ok = 0, waiting = 0, mul_due = 0;
    int   age, l_cmd;
    bit   l_mode, l_cin;

    logic [7:0] va [3] = '{8'h5A, 8'h7F, 8'h00};
    logic [7:0] vb [3] = '{8'hC3, 8'h03, 8'h01};
    logic       vc [3] = '{1'b1, 1'b0, 1'b1};

    alu_core #(.WIDTH(8), .CWIDTH(4), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
        .CMD(CMD), .CIN(CIN), .OPA(OPA), .OPB(OPB), .RES(RES), .COUT(COUT),
        .OFLOW(OFLOW), .E(E), .G(G), .L(L), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // 0 illegal, 1 needs A only, 2 needs B only, 3 needs both
    function automatic int op_kind(input bit mode, input int cmd);
        if (mode) begin
            if (cmd inside {0, 1, 2, 3, 8, 9, 10}) return 3;
            if (cmd inside {4, 5}) return 1;
            if (cmd inside {6, 7}) return 2;
            return 0;
        end
        if (cmd inside {[0:5], 12, 13}) return 3;
        if (cmd inside {6, 8, 9}) return 1;
        if (cmd inside {7, 10, 11}) return 2;
        return 0;
    endfunction

    function automatic exp_t err_o();
        exp_t o = '0;
        o.err = 1'b1;
        return o;
    endfunction

    function automatic exp_t model_eval(input bit mode, input int cmd, input bit cin,
                                        input int a, input int b);
        exp_t o = '0;
        int s, sa, sb, sr, p, r;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        if (mode) begin
            case (cmd)
                0, 2: begin
                    s = a + b + ((cmd == 2) ? int'(cin) : 0);
                    sr = sa + sb + ((cmd == 2) ? int'(cin) : 0);
                    o.res = 10'(s); o.cout = (s > 255); o.oflow = (sr > 127 || sr < -128);
                end
                1, 3: begin
                    s = a - b - ((cmd == 3) ? int'(cin) : 0);
                    sr = sa - sb - ((cmd == 3) ? int'(cin) : 0);
                    o.res = 10'(s & 511); o.cout = (s < 0); o.oflow = (sr > 127 || sr < -128);
                end
                4: begin s = a + 1; o.res = 10'(s); o.cout = (s > 255); end
                5: begin s = a - 1; o.res = 10'(s & 511); o.cout = (s < 0); end
                6: begin s = b + 1; o.res = 10'(s); o.cout = (s > 255); end
                7: begin s = b - 1; o.res = 10'(s & 511); o.cout = (s < 0); end
                8: begin o.e = (a == b); o.g = (a > b); o.l = (a < b); end
                9, 10: begin
                    p = (cmd == 9) ? (a + 1) * (b + 1) : (a * 2) * b;
                    o.res = 10'(p & 1023); o.oflow = (p > 1023);
                end
                default: o = err_o();
            endcase
        end else begin
            case (cmd)
                0: r = a & b;
                1: r = ~(a & b) & 255;
                2: r = a | b;
                3: r = ~(a | b) & 255;
                4: r = a ^ b;
                5: r = ~(a ^ b) & 255;
                6: r = ~a & 255;
                7: r = ~b & 255;
                8: r = a >> 1;
                9: r = (a << 1) & 255;
                10: r = b >> 1;
                11: r = (b << 1) & 255;
                12, 13: begin
                    r = a;
                    for (int i = 0; i < (b & 7); i++)
                        r = (cmd == 12) ? (((r << 1) | (r >> 7)) & 255)
                                        : (((r >> 1) | ((r & 1) << 7)) & 255);
                end
                default: r = 0;
            endcase
            if (cmd > 13 || ((cmd == 12 || cmd == 13) && b > 7)) o = err_o();
            else o.res = 10'(r);
        end
        return o;
    endfunction

    task automatic model_apply(input bit mode, input int cmd, input bit cin);
        exp_t r;
        r = model_eval(mode, cmd, cin, int'(OPA), int'(OPB));
        if (mode && (cmd == 9 || cmd == 10)) begin
            mul_val = r;
            mul_due = 1;
        end else begin
            exp_o = r;
        end
    endtask

    // Reference: what the outputs must show after each clock edge.
    always @(posedge CLK) begin
        int k;
        if (RST) model_ok = 1;
        if (RST || !CE) begin
            exp_o = '0; waiting = 0; mul_due = 0;
        end else if (mul_due) begin
            exp_o = mul_val; mul_due = 0;
        end else if (waiting) begin
            age++;
            if (age >= TIMEOUT) begin
                exp_o = err_o(); waiting = 0;
            end else if (INP_VALID == 2'b11) begin
                waiting = 0;
                model_apply(l_mode, l_cmd, l_cin);
            end
        end else if (INP_VALID != 2'b00) begin
            k = op_kind(MODE, int'(CMD));
            if (k == 0) exp_o = err_o();
            else if (k == 3 && INP_VALID != 2'b11) begin
                waiting = 1; age = 0; l_mode = MODE; l_cmd = int'(CMD); l_cin = CIN;
            end else if ((k == 1 && !INP_VALID[0]) || (k == 2 && !INP_VALID[1])) exp_o = err_o();
            else model_apply(MODE, int'(CMD), CIN);
        end
    end

    always @(negedge CLK) begin
        if (model_ok) begin
            n_cmp++;
            if ({RES, COUT, OFLOW, E, G, L, ERR} !== exp_o) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got res=%h cout=%b oflow=%b egl=%b%b%b err=%b, want res=%h cout=%b oflow=%b egl=%b%b%b err=%b",
                         $time, RES, COUT, OFLOW, E, G, L, ERR, exp_o.res, exp_o.cout,
                         exp_o.oflow, exp_o.e, exp_o.g, exp_o.l, exp_o.err);
            end
        end
    end

    task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic step(input logic [1:0] iv, input logic md, input logic [3:0] cm,
                        input logic ci, input logic [7:0] a, input logic [7:0] b);
        INP_VALID = iv; MODE = md; CMD = cm; CIN = ci; OPA = a; OPB = b;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST = 1; CE = 1; INP_VALID = 0; MODE = 0; CMD = 0; CIN = 0; OPA = 0; OPB = 0;
        @(posedge CLK); #2;
        @(posedge CLK); #2;
        lit("reset_outputs", 16'({RES, COUT, OFLOW, E, G, L, ERR}), 16'h0);
        RST = 0;

        step(2'b11, 1, 0, 0, 8'hFF, 8'h01);
        lit("add_res", 16'(RES), 16'h100);
        lit("add_cout_oflow_err", 16'({COUT, OFLOW, ERR}), 16'b100);

        step(2'b11, 1, 8, 0, 8'd5, 8'd9);
        lit("cmp_lt_egl", 16'({E, G, L}), 16'b001);
        lit("cmp_lt_res", 16'(RES), 16'h0);
        step(2'b11, 1, 8, 0, 8'd7, 8'd7);
        lit("cmp_eq_egl", 16'({E, G, L}), 16'b100);

        step(2'b01, 1, 0, 0, 8'd3, 8'd0);
        repeat (15) step(2'b00, 1, 0, 0, 8'd3, 8'd0);
        lit("wait_15_no_err", 16'(ERR), 16'h0);
        step(2'b00, 1, 0, 0, 8'd3, 8'd0);
        lit("timeout_err", 16'({RES, ERR}), 16'h001);

        step(2'b01, 1, 0, 0, 8'd3, 8'd0);
        repeat (14) step(2'b00, 1, 1, 0, 8'd3, 8'd0);
        step(2'b11, 1, 1, 0, 8'd3, 8'd4);
        lit("late_opb_res", 16'(RES), 16'd7);
        lit("late_opb_err", 16'(ERR), 16'h0);

        step(2'b11, 1, 9, 0, 8'd3, 8'd4);
        lit("mul_not_yet", 16'(RES), 16'd7);
        step(2'b11, 1, 0, 0, 8'd1, 8'd1);
        lit("mul_res", 16'(RES), 16'd20);
        step(2'b00, 1, 0, 0, 8'd1, 8'd1);
        lit("mul_drop_add", 16'(RES), 16'd20);

        step(2'b01, 1, 0, 0, 8'd5, 8'd0);
        CE = 0;
        step(2'b00, 1, 0, 0, 8'd5, 8'd0);
        lit("ce_clear", 16'({RES, COUT, OFLOW, E, G, L, ERR}), 16'h0);
        CE = 1;
        step(2'b11, 1, 0, 0, 8'd1, 8'd1);
        lit("after_ce_add", 16'(RES), 16'd2);

        step(2'b11, 1, 9, 0, 8'd3, 8'd4);
        RST = 1;
        step(2'b00, 1, 0, 0, 8'd0, 8'd0);
        lit("rst_mid_mul", 16'({RES, COUT, OFLOW, E, G, L, ERR}), 16'h0);
        RST = 0;
        step(2'b00, 1, 0, 0, 8'd0, 8'd0);
        lit("no_product_after_rst", 16'(RES), 16'h0);

        step(2'b11, 0, 12, 0, 8'h81, 8'h01);
        lit("rol_res", 16'({RES, ERR}), 16'(10'h003) << 1);
        step(2'b11, 0, 12, 0, 8'h81, 8'h10);
        lit("rol_bad_amt", 16'({RES, ERR}), 16'h001);
        step(2'b11, 1, 12, 0, 8'h81, 8'h01);
        lit("arith_cmd12_err", 16'(ERR), 16'h1);

        step(2'b11, 1, 1, 0, 8'd2, 8'd5);
        lit("sub_borrow", 16'({RES, COUT}), 16'(10'h1FD) << 1 | 16'h1);
        step(2'b11, 1, 0, 0, 8'h7F, 8'h01);
        lit("add_signed_ovf", 16'({RES, OFLOW}), 16'(10'h080) << 1 | 16'h1);
        step(2'b10, 1, 4, 0, 8'd9, 8'd9);
        lit("inc_a_missing", 16'({RES, ERR}), 16'h001);
        step(2'b00, 1, 0, 0, 8'd1, 8'd1);

        for (int v = 0; v < 3; v++)
            for (int m = 0; m < 2; m++)
                for (int c = 0; c < 16; c++) begin
                    step(2'b11, m[0], 4'(c), vc[v], va[v], vb[v]);
                    step(2'b00, m[0], 4'(c), vc[v], va[v], vb[v]);
                end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
